// File: rtl/alu_mc_pkg.sv
// Shared opcode, state and condition-code definitions for the multi-cycle ALU.
package alu_mc_pkg;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_AND  = 6'h01;
    localparam logic [5:0] OP_OR   = 6'h02;
    localparam logic [5:0] OP_XOR  = 6'h03;
    localparam logic [5:0] OP_SUB  = 6'h04;
    localparam logic [5:0] OP_ANDN = 6'h05;
    localparam logic [5:0] OP_ORN  = 6'h06;
    localparam logic [5:0] OP_XNOR = 6'h07;
    localparam logic [5:0] OP_ADDX = 6'h08;
    localparam logic [5:0] OP_UMUL = 6'h0A;
    localparam logic [5:0] OP_SMUL = 6'h0B;
    localparam logic [5:0] OP_SUBX = 6'h0C;
    localparam logic [5:0] OP_SLL  = 6'h25;
    localparam logic [5:0] OP_SRL  = 6'h26;
    localparam logic [5:0] OP_SRA  = 6'h27;

    localparam int CC_BIT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative radix-2 shift-add multiplier; signed mode multiplies magnitudes and
// negates the product. done/product are combinational on the last iteration.
module alu_mc_mul
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic                 r_busy;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_a_mag = (signed_mode && a[WIDTH-1]) ? (~a + ONE) : a;
    assign w_b_mag = (signed_mode && b[WIDTH-1]) ? (~b + ONE) : b;

    // Multiplier sits in the low half and is consumed one bit per cycle.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + {1'b0, (r_acc[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    assign done    = r_busy && (r_cnt == CW'(WIDTH-1));
    assign product = r_neg ? (~w_acc_next + {{WIDTH{1'b0}}, ONE}) : w_acc_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_neg   <= 1'b0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_mcand <= w_a_mag;
            r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
            r_neg   <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
            if (done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU with registered result, Y and icc; single-cycle
// add/sub/logic/shift ops plus an iterative multiply.
//   state | meaning
//   IDLE  | ready; single-cycle ops complete at the accepting edge
//   MUL   | multiply in progress, in_ready low for WIDTH cycles
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] y,
    output logic [3:0]       icc,
    output logic             illegal_op
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 r_out_valid;
    logic                 r_illegal;
    logic [WIDTH-1:0]     r_res;
    logic [WIDTH-1:0]     r_y;
    logic [3:0]           r_icc;
    logic                 r_mul_cc;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_cin;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_diff;
    logic [5:0]           w_base;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;
    logic                 w_legal;
    logic                 w_is_mul;
    logic                 w_wr_icc;
    logic [3:0]           w_icc_new;
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_prod;

    assign w_accept = in_valid && w_in_ready;

    // Only ADDX/SUBX have bit 3 set among the add/sub codes, so they take icc.C.
    assign w_cin  = op[3] ? r_icc[ICC_C] : 1'b0;
    assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
    assign w_diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, w_cin};
    assign w_base = {2'b00, op[3:0]};

    always_comb begin
        w_res    = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_legal  = 1'b1;
        w_is_mul = 1'b0;
        w_wr_icc = 1'b0;
        if (op[5]) begin
            case (op)
                OP_SLL:  w_res = a << b[SHW-1:0];
                OP_SRL:  w_res = a >> b[SHW-1:0];
                OP_SRA:  w_res = $signed(a) >>> b[SHW-1:0];
                default: w_legal = 1'b0;
            endcase
        end else begin
            w_wr_icc = op[CC_BIT];
            case (w_base)
                OP_ADD, OP_ADDX: begin
                    w_res = w_sum[WIDTH-1:0];
                    w_c   = w_sum[WIDTH];
                    w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB, OP_SUBX: begin
                    w_res = w_diff[WIDTH-1:0];
                    w_c   = w_diff[WIDTH];
                    w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
                end
                OP_AND:  w_res = a & b;
                OP_OR:   w_res = a | b;
                OP_XOR:  w_res = a ^ b;
                OP_ANDN: w_res = a & ~b;
                OP_ORN:  w_res = a | ~b;
                OP_XNOR: w_res = ~(a ^ b);
                OP_UMUL, OP_SMUL: w_is_mul = 1'b1;
                default: begin
                    w_legal  = 1'b0;
                    w_wr_icc = 1'b0;
                end
            endcase
        end
    end

    assign w_icc_new   = {w_res[WIDTH-1], (w_res == '0), w_v, w_c};
    assign w_mul_start = w_accept && w_is_mul;

    alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (w_mul_start),
        .a           (a),
        .b           (b),
        .signed_mode (op[0]),
        .done        (w_mul_done),
        .product     (w_prod)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_nxt = MUL;
            MUL:     if (w_mul_done)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = (r_state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            r_res       <= '0;
            r_y         <= '0;
            r_icc       <= '0;
            r_mul_cc    <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            if (w_accept && !w_is_mul) begin
                r_out_valid <= 1'b1;
                r_illegal   <= !w_legal;
                r_res       <= w_res;
                if (w_wr_icc) begin
                    r_icc <= w_icc_new;
                end
            end
            if (w_mul_start) begin
                r_mul_cc <= op[CC_BIT];
            end
            if (w_mul_done) begin
                r_out_valid <= 1'b1;
                r_res       <= w_prod[WIDTH-1:0];
                r_y         <= w_prod[2*WIDTH-1:WIDTH];
                if (r_mul_cc) begin
                    r_icc <= {w_prod[WIDTH-1], (w_prod[WIDTH-1:0] == '0), 2'b00};
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign illegal_op = r_illegal;
    assign res        = r_res;
    assign y          = r_y;
    assign icc        = r_icc;

endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc with hand-computed results and flags.
module tb_alu_mc;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [5:0]    op = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          out_valid;
    logic [W-1:0]  res;
    logic [W-1:0]  y;
    logic [3:0]    icc;
    logic          illegal_op;

    int n_vec = 0;
    int n_err = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .res        (res),
        .y          (y),
        .icc        (icc),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        @(negedge clk);
        op       = o;
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] e_res, input logic [3:0] e_icc);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_res"}, 64'(res), 64'(e_res));
        chk({tag, "_icc"}, 64'(icc), 64'(e_icc));
        chk({tag, "_illegal"}, 64'(illegal_op), 64'd0);
    endtask

    task automatic wait_mul(input string tag);
        int lat;
        int rdy_hi;
        lat    = 1;
        rdy_hi = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_hi++;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
        chk({tag, "_busy_ready"}, 64'(rdy_hi), 64'd0);
        chk({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int ov_cnt;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_icc", 64'(icc), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_illegal", 64'(illegal_op), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        issue(6'h10, 32'hFFFF_FFFF, 32'h0000_0001);
        check_res("addcc_wrap", 32'h0000_0000, 4'b0101);
        @(posedge clk);
        #1;
        chk("addcc_pulse", 64'(out_valid), 64'd0);

        issue(6'h08, 32'h0000_0005, 32'h0000_0000);
        check_res("addx_c1", 32'h0000_0006, 4'b0101);

        issue(6'h10, 32'h7FFF_FFFF, 32'h0000_0001);
        check_res("addcc_ovf", 32'h8000_0000, 4'b1010);
        chk("b2b_ready1", 64'(in_ready), 64'd1);
        issue(6'h08, 32'h0000_0000, 32'h0000_0000);
        check_res("addx_c0", 32'h0000_0000, 4'b1010);
        chk("b2b_ready2", 64'(in_ready), 64'd1);

        issue(6'h14, 32'h0000_0000, 32'h0000_0001);
        check_res("subcc_borrow", 32'hFFFF_FFFF, 4'b1001);
        issue(6'h0C, 32'h0000_0005, 32'h0000_0000);
        check_res("subx_b1", 32'h0000_0004, 4'b1001);

        issue(6'h1B, 32'hFFFF_FFFD, 32'h0000_0007);
        wait_mul("smulcc");
        check_res("smulcc", 32'hFFFF_FFEB, 4'b1000);
        chk("smulcc_y", 64'(y), 64'h0000_0000_FFFF_FFFF);

        issue(6'h0A, 32'h0001_0000, 32'h0003_0000);
        wait_mul("umul");
        check_res("umul", 32'h0000_0000, 4'b1000);
        chk("umul_y", 64'(y), 64'h0000_0000_0000_0003);

        issue(6'h27, 32'h8000_0000, 32'h0000_0124);
        check_res("sra", 32'hF800_0000, 4'b1000);
        issue(6'h25, 32'h0000_0001, 32'hFFFF_FFFF);
        check_res("sll", 32'h8000_0000, 4'b1000);
        issue(6'h26, 32'h8000_0000, 32'h0000_0004);
        check_res("srl", 32'h0800_0000, 4'b1000);

        issue(6'h3F, 32'h1234_5678, 32'h9ABC_DEF0);
        chk("ill_valid", 64'(out_valid), 64'd1);
        chk("ill_flag", 64'(illegal_op), 64'd1);
        chk("ill_res", 64'(res), 64'd0);
        chk("ill_icc", 64'(icc), 64'(4'b1000));
        chk("ill_y", 64'(y), 64'd3);

        issue(6'h17, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        check_res("xnorcc", 32'h0000_0000, 4'b0100);
        issue(6'h05, 32'hFF00_FF00, 32'h0F0F_0F0F);
        check_res("andn", 32'hF000_F000, 4'b0100);
        issue(6'h12, 32'h8000_0000, 32'h0000_0001);
        check_res("orcc", 32'h8000_0001, 4'b1000);

        issue(6'h1A, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_mul("umulcc");
        check_res("umulcc", 32'h0000_0001, 4'b0000);
        chk("umulcc_y", 64'(y), 64'h0000_0000_FFFF_FFFE);

        issue(6'h1A, 32'h0000_0003, 32'h0000_0005);
        wait_mul("umulcc_prep");
        check_res("umulcc_prep", 32'h0000_000F, 4'b0000);
        issue(6'h14, 32'h0000_0000, 32'h0000_0001);
        check_res("subcc_prep", 32'hFFFF_FFFF, 4'b1001);

        issue(6'h0A, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (8) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_y", 64'(y), 64'd0);
        chk("abort_icc", 64'(icc), 64'd0);
        chk("abort_res", 64'(res), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_cnt++;
        end
        chk("abort_no_valid", 64'(ov_cnt), 64'd0);
        chk("abort_idle_ready", 64'(in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
